if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction fetch stage that drives the IF/ID pipeline register. It owns the program counter and issues one-outstanding requests to instruction memory. It presents each returned instruction with its PC and a valid flag to the decode side, honours the downstream stall, and redirects on taken branches.

## Interface
Parameters:
- PC_W, 8, PC and instruction-memory byte-address width
- RESET_PC, 8'h00, first fetch address after reset; low 2 bits must be 0

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  IF/ID cannot accept; hold outputs
- redirect_valid  in  1  taken branch: flush and refetch
- redirect_pc  in  PC_W  branch target; bits [1:0] ignored (forced 0)
- imem_req  out  1  request to instruction memory
- imem_addr  out  PC_W  request address, word aligned
- imem_ack  in  1  response valid this cycle; may be same cycle as req
- imem_rdata  in  32  instruction word, valid with imem_ack
- instruction_out  out  32  instruction toward IF/ID
- pc_out  out  PC_W  PC of instruction_out
- out_valid  out  1  instruction_out/pc_out hold a real instruction

## Operation
- Reset values: imem_req=0, imem_addr=RESET_PC, instruction_out=32'h00000013 (NOP), pc_out=0, out_valid=0, state=FETCH, fetch_pc=RESET_PC, buffer empty, discard=0.
- State FETCH:
  - imem_req=1, imem_addr=fetch_pc.
  - On imem_ack with stall=0: the output register loads {rdata, fetch_pc}, out_valid=1, and fetch_pc += 4.
  - On imem_ack with stall=1: the word goes to a one-entry hold buffer, fetch_pc += 4, and the state moves to HOLD.
- State HOLD:
  - imem_req=0.
  - When stall drops, the output loads the buffered word and the state returns to FETCH.
- State DRAIN:
  - imem_req=1 and imem_addr is held at the old address.
  - The next imem_ack data is discarded.
  - Then fetch_pc=redirect target and the state returns to FETCH.
- Without stall or redirect, the output register keeps its last contents. out_valid drops to 0 only when the cycle had no ack and stall=0.
- Address rules:
  - imem_addr must not change while imem_req=1 and no ack has arrived.
  - The PC increments modulo 2^PC_W, so 8'hFC wraps to 8'h00.
- Redirect (highest priority, overrides stall):
  - Next cycle: out_valid=0, instruction_out=NOP, and the hold buffer is cleared.
  - If a request is pending without ack in the redirect cycle, the target is latched and the state goes to DRAIN.
  - Otherwise, including an ack in the same cycle (whose data is dropped), fetch_pc=target and the state goes to FETCH.
  - A redirect while in DRAIN overwrites the latched target.
- rst asserted mid-request returns everything to reset values. A late ack afterwards is ignored unless imem_req=1.

## Timing
- Zero-wait memory (ack same cycle as req): one instruction per cycle; data acked in cycle n appears on instruction_out in cycle n+1.
- N-cycle memory: one instruction per N+1 cycles.
- Redirect in cycle n with no request pending: the first target instruction is valid no earlier than cycle n+2.
- Stall in cycle n: outputs are frozen in n+1. At most one word is buffered; no new request is issued while the buffer is full.

## Configuration
- FETCH_TRACE_EN defined:
  - Every cycle that loads a valid instruction into the output register prints time, PC, instruction hex and opcode class (R, I-ALU, load, store, branch, undefined) via $display.
  - Redirects print the target.
- FETCH_TRACE_EN not defined: no trace logic or $display is compiled. Behaviour is cycle-identical.

## Structure
- Shared package rv_pipe_pkg holds:
  - the NOP constant 32'h00000013
  - opcode constants 7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011
  - the fetch state enum (FETCH, HOLD, DRAIN)
- One sub-module, if_trace: opcode classification and printing, instantiated only under FETCH_TRACE_EN.
- The PC, FSM, hold buffer and output register are in the top module.

## Test plan
- Reset, then zero-wait memory returning 0x00500093 at 0x00 and 0x00A00113 at 0x04: out_valid rises the cycle after the first ack, pc_out=0x00 then 0x04, one per cycle.
- Stall held 3 cycles while ack arrives at 0x08: outputs frozen, imem_req=0 in HOLD; after release instruction_out shows the 0x08 word and no word is lost or duplicated.
- Redirect to 0x40 with 2-cycle memory and a request pending to 0x0C: the 0x0C data is discarded, the next imem_addr is 0x40, and out_valid=0 with NOP until 0x40 returns.
- Redirect in the same cycle as ack and stall=1: the ack data is dropped, the buffer is empty, and the next request is 0x40.
- fetch_pc at 0xFC: the next imem_addr is 0x00. redirect_pc=0x43 is requested as 0x40.
- rst pulsed while imem_req=1: the next cycle shows all reset values and the subsequent fetch is at RESET_PC.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, base-ISA major opcodes and the fetch FSM states.
package rv_pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_trace.sv
// Fetch trace printer: classifies each loaded instruction and logs redirects.
// Only compiled when FETCH_TRACE_EN is defined.
`ifdef FETCH_TRACE_EN
module if_trace
  import rv_pipe_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input logic            clk,
  input logic            rst,
  input logic            load_en,
  input logic [PC_W-1:0] load_pc,
  input logic [31:0]     load_instr,
  input logic            redirect_valid,
  input logic [PC_W-1:0] redirect_target
);

  function automatic string op_class(input logic [6:0] opc);
    case (opc)
      OPC_R:      return "R";
      OPC_I_ALU:  return "I-ALU";
      OPC_LOAD:   return "load";
      OPC_STORE:  return "store";
      OPC_BRANCH: return "branch";
      default:    return "undefined";
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_en)
        $display("[%0t] fetch pc=%h instr=%h class=%s", $time, load_pc, load_instr,
                 op_class(load_instr[6:0]));
      if (redirect_valid)
        $display("[%0t] redirect target=%h", $time, redirect_target);
    end
  end

endmodule
`endif

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding imem requests, one-entry stall buffer, IF/ID register.
// Optional trace output enabled by defining FETCH_TRACE_EN.
module if_fetch_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction_out,
  output logic [PC_W-1:0] pc_out,
  output logic            out_valid
);

  fetch_state_e    state_reg, state_next;
  logic [PC_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [PC_W-1:0] drain_pc_reg, drain_pc_next;
  logic [PC_W-1:0] buf_pc_reg, buf_pc_next;
  logic [31:0]     buf_data_reg, buf_data_next;
  logic [31:0]     instr_reg, instr_next;
  logic [PC_W-1:0] pc_out_reg, pc_out_next;
  logic            out_valid_reg, out_valid_next;
  logic            req_reg, req_next;

  logic            ack_fire;
  logic            load_en;
  logic [31:0]     load_instr;
  logic [PC_W-1:0] load_pc;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] pc_plus4;

  // An ack only counts while a request is actually outstanding.
  assign ack_fire        = req_reg & imem_ack;
  assign redirect_target = {redirect_pc[PC_W-1:2], 2'b00};
  assign pc_plus4        = fetch_pc_reg + PC_W'(4);

  always_comb begin
    load_en    = 1'b0;
    load_instr = imem_rdata;
    load_pc    = fetch_pc_reg;
    if (!redirect_valid && !stall) begin
      if (state_reg == FETCH && ack_fire) begin
        load_en = 1'b1;
      end else if (state_reg == HOLD) begin
        load_en    = 1'b1;
        load_instr = buf_data_reg;
        load_pc    = buf_pc_reg;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    drain_pc_next  = drain_pc_reg;
    buf_data_next  = buf_data_reg;
    buf_pc_next    = buf_pc_reg;
    instr_next     = instr_reg;
    pc_out_next    = pc_out_reg;
    out_valid_next = out_valid_reg;

    if (!ack_fire && !stall) out_valid_next = 1'b0;
    if (load_en) begin
      instr_next     = load_instr;
      pc_out_next    = load_pc;
      out_valid_next = 1'b1;
    end

    if (redirect_valid) begin
      instr_next     = NOP_INSTR;
      out_valid_next = 1'b0;
      // A request still in flight must be drained before the target can be issued.
      if (req_reg && !imem_ack) begin
        drain_pc_next = redirect_target;
        state_next    = DRAIN;
      end else begin
        fetch_pc_next = redirect_target;
        state_next    = FETCH;
      end
    end else begin
      unique case (state_reg)
        FETCH: begin
          if (ack_fire) begin
            fetch_pc_next = pc_plus4;
            if (stall) begin
              buf_data_next = imem_rdata;
              buf_pc_next   = fetch_pc_reg;
              state_next    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) state_next = FETCH;
        end
        DRAIN: begin
          if (ack_fire) begin
            fetch_pc_next = drain_pc_reg;
            state_next    = FETCH;
          end
        end
        default: state_next = FETCH;
      endcase
    end

    req_next = (state_next != HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= FETCH;
      fetch_pc_reg  <= RESET_PC;
      drain_pc_reg  <= RESET_PC;
      buf_data_reg  <= NOP_INSTR;
      buf_pc_reg    <= '0;
      instr_reg     <= NOP_INSTR;
      pc_out_reg    <= '0;
      out_valid_reg <= 1'b0;
      req_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      drain_pc_reg  <= drain_pc_next;
      buf_data_reg  <= buf_data_next;
      buf_pc_reg    <= buf_pc_next;
      instr_reg     <= instr_next;
      pc_out_reg    <= pc_out_next;
      out_valid_reg <= out_valid_next;
      req_reg       <= req_next;
    end
  end

  // fetch_pc is left untouched during DRAIN, so it doubles as the held request address.
  assign imem_req        = req_reg;
  assign imem_addr       = fetch_pc_reg;
  assign instruction_out = instr_reg;
  assign pc_out          = pc_out_reg;
  assign out_valid       = out_valid_reg;

`ifdef FETCH_TRACE_EN
  if_trace #(.PC_W(PC_W)) u_trace (
    .clk             (clk),
    .rst             (rst),
    .load_en         (load_en),
    .load_pc         (load_pc),
    .load_instr      (load_instr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target)
  );
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage: variable-latency memory model plus an in-order
// instruction-stream scoreboard that tracks redirects, owed discards and the stall buffer.
module tb_if_fetch_stage;
  import rv_pipe_pkg::*;

  localparam logic [7:0] RESET_PC = 8'h00;
  localparam int         NCYC     = 3000;
  localparam int         CALM     = 150;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [7:0]  pc_out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch_stage #(.PC_W(8), .RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .out_valid       (out_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {8'hA5 ^ a, a, ~a, a + 8'd3};
  endfunction

  initial begin
    logic [7:0]  exp_pc;
    logic [7:0]  p_addr, p_pc, p_rpc;
    logic [31:0] p_instr;
    logic        p_rst, p_stall, p_redir, p_req, p_ack, p_valid;
    bit          owed, buffered, noisy;
    int          mem_wait, delivered;

    exp_pc = RESET_PC; owed = 0; buffered = 0; mem_wait = 0; delivered = 0;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    p_rst = 1'b1; p_stall = 1'b0; p_redir = 1'b0; p_rpc = 8'h00;
    p_req = 1'b0; p_ack = 1'b0; p_addr = 8'h00; p_pc = 8'h00; p_instr = 32'h0; p_valid = 1'b0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (p_rst) begin
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, RESET_PC);
        check_eq("rst_instr", instruction_out, NOP_INSTR);
        check_eq("rst_pc", pc_out, 8'h00);
        check_eq("rst_valid", out_valid, 1'b0);
        exp_pc = RESET_PC; owed = 0; buffered = 0;
      end else begin
        if (p_req && !p_ack) begin
          check_eq("addr_hold_req", imem_req, 1'b1);
          check_eq("addr_hold", imem_addr, p_addr);
        end
        if (p_redir) begin
          check_eq("redir_valid", out_valid, 1'b0);
          check_eq("redir_nop", instruction_out, NOP_INSTR);
          exp_pc   = {p_rpc[7:2], 2'b00};
          buffered = 0;
          owed     = p_req && !p_ack;
        end else if (owed && p_req && p_ack) begin
          check_eq("discard_valid", out_valid, 1'b0);
          owed = 0;
        end else if (p_stall) begin
          check_eq("frozen_valid", out_valid, p_valid);
          check_eq("frozen_instr", instruction_out, p_instr);
          check_eq("frozen_pc", pc_out, p_pc);
          if (p_req && p_ack) buffered = 1;
        end else begin
          check_eq("valid", out_valid, (p_req && p_ack) || buffered);
          if (out_valid) begin
            check_eq("stream_pc", pc_out, exp_pc);
            check_eq("stream_instr", instruction_out, mem_word(exp_pc));
            exp_pc = exp_pc + 8'd4;
            delivered++;
          end
          buffered = 0;
        end
        if (buffered) check_eq("no_req_full", imem_req, 1'b0);
      end

      p_valid = out_valid; p_instr = instruction_out; p_pc = pc_out;
      p_req   = imem_req;  p_addr  = imem_addr;

      noisy = (cyc >= CALM);
      if (noisy && $urandom_range(99) == 0) begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
        mem_wait = 0;
      end else begin
        rst            = 1'b0;
        stall          = noisy && ($urandom_range(3) == 0);
        redirect_valid = noisy && ($urandom_range(19) == 0);
        redirect_pc    = 8'($urandom_range(255));
        if (cyc == CALM + 10) begin
          redirect_valid = 1'b1;
          redirect_pc    = 8'h43;
        end
        if (imem_req) begin
          if (mem_wait == 0) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            mem_wait   = noisy ? int'($urandom_range(2)) : 0;
          end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0BAD_F00D;
            mem_wait--;
          end
        end else begin
          imem_ack   = noisy && ($urandom_range(4) == 0);
          imem_rdata = 32'hDEAD_BEEF;
        end
      end
      p_rst = rst; p_stall = stall; p_redir = redirect_valid;
      p_rpc = redirect_pc; p_ack = imem_ack;
    end

    check_eq("progress", delivered > 300, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
